mips_writeback_stage: RTL and testbench
=======================================

# mips_writeback_stage

Final pipeline stage of the 32-bit MIPS core, directly downstream of the memory-access stage. It registers that stage's result (load data or ALU result), extracts and extends sub-word loads, and writes the destination register. It owns the 32×32 architectural register file, with two combinational read ports for decode, and exports forwarding info and a retired-instruction counter.

## Interface
Parameters:
- `NREGS`, 32: architectural register count; `rd` width is log2(NREGS).
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_valid`  in  1  memory stage presents a valid instruction.
- `mem_op`  in  `mem_op_e`  memory operation of that instruction.
- `mem_we`  in  1  instruction writes a register.
- `mem_rd`  in  5  destination register.
- `mem_alu_result`  in  32  ALU result / effective address.
- `mem_load_data`  in  32  word returned by the memory stage.
- `stall`  in  1  hold the stage register.
- `flush`  in  1  discard the incoming instruction.
- `rs_addr`, `rt_addr`  in  5 each  decode read addresses.
- `rs_data`, `rt_data`  out  32 each  register read data, with write bypass.
- `wb_valid`  out  1  stage register holds a valid instruction.
- `wb_we`  out  1  that instruction writes `wb_rd`; forced 0 when `wb_rd`==0.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  final write data; also the forwarding value.
- `instret`  out  32  retired-instruction count.

## Operation
- Stage register S holds {valid, op, we, rd, alu_result, load_data}.
- Each edge:
  - `rst` clears S.
  - else `flush` sets S.valid=0.
  - else `!stall` loads S from the `mem_*` inputs.
  - else S holds.
- `flush` has priority over `stall`.
- `wb_data` is combinational from S, little-endian, with lane = `alu_result[1:0]`:
  - `MEM_OP_LW`: load_data.
  - `MEM_OP_LB` / `MEM_OP_LBU`: byte at lane, sign- or zero-extended.
  - `MEM_OP_LH` / `MEM_OP_LHU`: halfword selected by `alu_result[1]` (bit 0 ignored), sign- or zero-extended.
  - `MEM_OP_SW` / `MEM_OP_NONE`: alu_result.
- `wb_we` = S.valid & S.we & (S.rd!=0) & (S.op!=`MEM_OP_SW`).
- Register write at each edge where `wb_we`=1, repeated while stalled (idempotent). Register 0 is never written and always reads 0.
- Read ports are combinational. If `wb_we` and the read address equals `wb_rd`, return `wb_data` (write-first bypass); address 0 returns 0.
- `instret` increments by 1 on each edge where S.valid & (!stall | flush), so each instruction is counted once, as it leaves S. It wraps 0xFFFF_FFFF→0.

## Timing
- Reset values: `wb_valid`=0, `wb_we`=0, `wb_rd`=0, `wb_data`=0, `instret`=0, all registers 0. `rs_data`/`rt_data` read 0 the cycle after reset.
- Latency: inputs captured at edge N, `wb_data` valid after N, register file updated at edge N+1. Decode sees the value via bypass during cycle N→N+1 and from the array afterwards.
- Reset mid-stall or mid-flush: reset wins. The S contents are dropped unwritten and uncounted.
- Flush arriving with S valid and stalled: the S instruction has already written, and is counted once at that edge.

## Structure
- Shared package `mips_pkg`: `mem_op_e` {`MEM_OP_NONE`, `MEM_OP_LW`, `MEM_OP_SW`, `MEM_OP_LB`, `MEM_OP_LBU`, `MEM_OP_LH`, `MEM_OP_LHU`}, `XLEN`, `REG_ZERO`=0.
- Sub-module `mips_regfile`: 32×32 array, one write port, two bypassed read ports, synchronous clear on `rst`.
- Load extraction stays inline in the stage.

## Test plan
- LB, `mem_load_data`=0x0000_8000, `alu_result`=0x1001 → `wb_data`=0xFFFF_FF80. LBU, same inputs → 0x0000_0080.
- LH, `alu_result`=0x2002, `mem_load_data`=0x8001_1234 → 0xFFFF_8001. LHU → 0x0000_8001.
- LW to r5 with data 0xDEAD_BEEF, `rs_addr`=5 in the same cycle → `rs_data`=0xDEAD_BEEF via bypass. The next cycle reads it from the array.
- Write to r0 with 0x1234 → `wb_we`=0, `rs_data` for address 0 = 0. SW with `mem_we`=1 → no write.
- Valid instr captured, `stall` held 3 cycles, then released → `wb_data` constant throughout, `instret` +1 only. `flush`+`stall` together → S.valid=0 next cycle.
- `instret` preset by 0xFFFF_FFFF retirements (or forced), one more retire → 0. Assert `rst` mid-stream → all outputs and registers 0 after the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS core pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        MEM_OP_NONE = 3'd0,
        MEM_OP_LW   = 3'd1,
        MEM_OP_SW   = 3'd2,
        MEM_OP_LB   = 3'd3,
        MEM_OP_LBU  = 3'd4,
        MEM_OP_LH   = 3'd5,
        MEM_OP_LHU  = 3'd6
    } mem_op_e;

    // Contents of the writeback stage register.
    typedef struct packed {
        logic              valid;
        mem_op_e           op;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   load_data;
    } wb_stage_t;

    function automatic logic [XLEN-1:0] extend8(input logic [7:0] b, input logic sgn);
        return {{(XLEN-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] extend16(input logic [15:0] h, input logic sgn);
        return {{(XLEN-16){sgn & h[15]}}, h};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : mips_regfile
//  Description : Architectural register file, one write port, two write-first
//                bypassed read ports, register 0 hardwired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile
    import mips_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] regs_q [NREGS];
    logic          w_wr;

    assign w_wr = we_i && (waddr_i != AW'(0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a,
                                              input logic          wr,
                                              input logic [AW-1:0] wa,
                                              input logic [DW-1:0] wd,
                                              input logic [DW-1:0] arr);
        if (a == AW'(0))          return '0;
        else if (wr && (a == wa)) return wd;
        else                      return arr;
    endfunction

    assign rdata_a_o = rd_port(raddr_a_i, w_wr, waddr_i, wdata_i, regs_q[raddr_a_i]);
    assign rdata_b_o = rd_port(raddr_b_i, w_wr, waddr_i, wdata_i, regs_q[raddr_b_i]);

endmodule
`default_nettype wire

// File: rtl/mips_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mips_writeback_stage
//  Description : Writeback stage: stage register, sub-word load extraction,
//                register file write and retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_writeback_stage
    import mips_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  mem_op_e                  mem_op,
    input  logic                     mem_we,
    input  logic [$clog2(NREGS)-1:0] mem_rd,
    input  logic [XLEN-1:0]          mem_alu_result,
    input  logic [XLEN-1:0]          mem_load_data,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [$clog2(NREGS)-1:0] rs_addr,
    input  logic [$clog2(NREGS)-1:0] rt_addr,
    output logic [XLEN-1:0]          rs_data,
    output logic [XLEN-1:0]          rt_data,
    output logic                     wb_valid,
    output logic                     wb_we,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic [31:0]              instret
);

    wb_stage_t   s_q;
    wb_stage_t   s_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        s_d = s_q;
        if (flush) begin
            s_d.valid = 1'b0;
        end else if (!stall) begin
            s_d.valid      = mem_valid;
            s_d.op         = mem_op;
            s_d.we         = mem_we;
            s_d.rd         = mem_rd;
            s_d.alu_result = mem_alu_result;
            s_d.load_data  = mem_load_data;
        end
    end

    // An instruction is counted exactly once, on the edge it leaves S.
    assign instret_d = instret_q + {31'd0, s_q.valid & (~stall | flush)};

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            instret_q <= '0;
        end else begin
            s_q       <= s_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        w_byte = s_q.load_data[7:0];
        case (s_q.alu_result[1:0])
            2'd1:    w_byte = s_q.load_data[15:8];
            2'd2:    w_byte = s_q.load_data[23:16];
            2'd3:    w_byte = s_q.load_data[31:24];
            default: w_byte = s_q.load_data[7:0];
        endcase
    end

    assign w_half = s_q.alu_result[1] ? s_q.load_data[31:16] : s_q.load_data[15:0];

    always_comb begin
        wb_data = s_q.alu_result;
        case (s_q.op)
            MEM_OP_LW:  wb_data = s_q.load_data;
            MEM_OP_LB:  wb_data = extend8(w_byte, 1'b1);
            MEM_OP_LBU: wb_data = extend8(w_byte, 1'b0);
            MEM_OP_LH:  wb_data = extend16(w_half, 1'b1);
            MEM_OP_LHU: wb_data = extend16(w_half, 1'b0);
            default:    wb_data = s_q.alu_result;
        endcase
    end

    assign wb_valid = s_q.valid;
    assign wb_rd    = s_q.rd;
    assign wb_we    = s_q.valid & s_q.we & (s_q.rd != REG_ZERO) & (s_q.op != MEM_OP_SW);
    assign instret  = instret_q;

    mips_regfile #(
        .NREGS (NREGS),
        .DW    (XLEN)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_we),
        .waddr_i   (wb_rd),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_addr),
        .raddr_b_i (rt_addr),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_mips_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_writeback_stage
//  Description : Directed, table-driven self-checking bench for the writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_writeback_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    mem_op_e     mem_op;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic        stall;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_writeback_stage #(
        .NREGS (32),
        .XLEN  (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_op         (mem_op),
        .mem_we         (mem_we),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .stall          (stall),
        .flush          (flush),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .instret        (instret)
    );

    typedef struct {
        mem_op_e     op;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_data;
        logic        exp_we;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input mem_op_e op, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld);
        mem_valid      = v;
        mem_op         = op;
        mem_we         = 1'b1;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_load_data  = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            op          rd     alu            ld             rs     rt     data           we    rs_exp         rt_exp
        tbl[0] = '{MEM_OP_LB,  5'd3,  32'h0000_1001, 32'h0000_8000, 5'd3,  5'd1,  32'hFFFF_FF80, 1'b1, 32'hFFFF_FF80, 32'h0};
        tbl[1] = '{MEM_OP_LBU, 5'd4,  32'h0000_1001, 32'h0000_8000, 5'd4,  5'd3,  32'h0000_0080, 1'b1, 32'h0000_0080, 32'hFFFF_FF80};
        tbl[2] = '{MEM_OP_LH,  5'd6,  32'h0000_2002, 32'h8001_1234, 5'd6,  5'd4,  32'hFFFF_8001, 1'b1, 32'hFFFF_8001, 32'h0000_0080};
        tbl[3] = '{MEM_OP_LHU, 5'd7,  32'h0000_2002, 32'h8001_1234, 5'd7,  5'd6,  32'h0000_8001, 1'b1, 32'h0000_8001, 32'hFFFF_8001};
        tbl[4] = '{MEM_OP_LW,  5'd5,  32'h0000_0100, 32'hDEAD_BEEF, 5'd5,  5'd7,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'h0000_8001};
        tbl[5] = '{MEM_OP_NONE,5'd0,  32'h0000_1234, 32'h0,         5'd0,  5'd5,  32'h0000_1234, 1'b0, 32'h0,         32'hDEAD_BEEF};
        tbl[6] = '{MEM_OP_SW,  5'd8,  32'h0000_0040, 32'h0,         5'd8,  5'd0,  32'h0000_0040, 1'b0, 32'h0,         32'h0};
        tbl[7] = '{MEM_OP_LB,  5'd9,  32'h0000_0003, 32'h7F00_0000, 5'd9,  5'd8,  32'h0000_007F, 1'b1, 32'h0000_007F, 32'h0};
        tbl[8] = '{MEM_OP_LH,  5'd10, 32'h0000_0001, 32'h0000_F00D, 5'd10, 5'd9,  32'hFFFF_F00D, 1'b1, 32'hFFFF_F00D, 32'h0000_007F};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; rs_addr = '0; rt_addr = '0;
        drive(1'b1, MEM_OP_LW, 5'd2, 32'h0, 32'hFFFF_FFFF);
        step(); step();
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b0; rs_addr = 5'd2; rt_addr = 5'd31;
        #1;
        check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset wb_we",    {31'd0, wb_we},    32'd0);
        check("reset wb_rd",    {27'd0, wb_rd},    32'd0);
        check("reset wb_data",  wb_data, 32'd0);
        check("reset instret",  instret, 32'd0);
        check("reset rs_data",  rs_data, 32'd0);
        check("reset rt_data",  rt_data, 32'd0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(1'b1, tbl[i].op, tbl[i].rd, tbl[i].alu, tbl[i].ld);
            rs_addr = tbl[i].rs;
            rt_addr = tbl[i].rt;
            step();
            check($sformatf("vec%0d wb_data", i), wb_data, tbl[i].exp_data);
            check($sformatf("vec%0d wb_we", i), {31'd0, wb_we}, {31'd0, tbl[i].exp_we});
            check($sformatf("vec%0d rs_data", i), rs_data, tbl[i].exp_rs);
            check($sformatf("vec%0d rt_data", i), rt_data, tbl[i].exp_rt);
            check($sformatf("vec%0d instret", i), instret, 32'(i));
        end

        // Stall hold: captured instruction stays put and is counted once.
        @(negedge clk);
        drive(1'b1, MEM_OP_LW, 5'd11, 32'h0, 32'h1111_2222);
        rt_addr = 5'd10;
        step();
        check("stall cap wb_data", wb_data, 32'h1111_2222);
        check("stall cap instret", instret, 32'd9);
        @(negedge clk);
        drive(1'b1, MEM_OP_LW, 5'd12, 32'h0, 32'h0000_3333);
        stall = 1'b1;
        rs_addr = 5'd11;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d wb_data", k), wb_data, 32'h1111_2222);
            check($sformatf("stall%0d instret", k), instret, 32'd9);
            check($sformatf("stall%0d rs_data", k), rs_data, 32'h1111_2222);
        end
        check("stall r10", rt_data, 32'hFFFF_F00D);
        @(negedge clk);
        stall = 1'b0;
        step();
        check("release instret", instret, 32'd10);
        check("release wb_rd", {27'd0, wb_rd}, 32'd12);
        check("release wb_data", wb_data, 32'h0000_3333);
        check("release r11", rs_data, 32'h1111_2222);

        // Flush with stall: flush wins, held instruction written and counted.
        @(negedge clk);
        stall = 1'b1; flush = 1'b1;
        rt_addr = 5'd12;
        step();
        check("flush wb_valid", {31'd0, wb_valid}, 32'd0);
        check("flush wb_we", {31'd0, wb_we}, 32'd0);
        check("flush instret", instret, 32'd11);
        check("flush r12", rt_data, 32'h0000_3333);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        step();
        check("idle instret", instret, 32'd11);

        // Counter wrap.
        @(negedge clk);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        drive(1'b1, MEM_OP_LW, 5'd13, 32'h0, 32'h0000_ABCD);
        rs_addr = 5'd13;
        step();
        check("wrap pre instret", instret, 32'hFFFF_FFFF);
        @(negedge clk);
        mem_valid = 1'b0;
        step();
        check("wrap instret", instret, 32'd0);
        check("wrap r13", rs_data, 32'h0000_ABCD);

        // Reset during a stall drops the held instruction.
        @(negedge clk);
        drive(1'b1, MEM_OP_LW, 5'd14, 32'h4, 32'h0000_5555);
        step();
        @(negedge clk);
        stall = 1'b1; rst = 1'b1;
        rs_addr = 5'd14; rt_addr = 5'd5;
        step();
        check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst wb_we", {31'd0, wb_we}, 32'd0);
        check("rst wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst wb_data", wb_data, 32'd0);
        check("rst instret", instret, 32'd0);
        check("rst r14", rs_data, 32'd0);
        check("rst r5", rt_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; mem_valid = 1'b0;
        rt_addr = 5'd12;
        step();
        check("post rst r12", rt_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
